// File: rtl/pdatapath_pkg.sv
// Shared types and default sizes for the sequenced datapath (pdatapath_seq and pdp_alu).
package pdatapath_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int RF_DEPTH_DEF  = 16;
    localparam int RAM_DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_ALU   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_NOT  = 3'd6,
        ALU_SHL  = 3'd7
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_LD_WAIT = 2'd2,
        ST_LD_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/pdp_alu.sv
// pdp_alu: combinational ALU, results wrap modulo 2^DATA_W.
// carry is the add carry-out or the subtract borrow (a < b unsigned), 0 otherwise.
module pdp_alu
    import pdatapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_sel_e          sel,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // the extra top bit of the widened subtract is the unsigned borrow
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (sel)
            ALU_PASS: result = a;
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SHL: result = {a[DATA_W-2:0], 1'b0};
            default: result = a;
        endcase
    end

endmodule

// File: rtl/pdatapath_seq.sv
// pdatapath_seq: accepts one LOAD/STORE/ALU/NOP micro-op at a time and sequences RF, RAM and ALU.
// Defining PDATAPATH_FLAGS_EN adds the registered ALU status flags FlagZ/FlagN/FlagC.
//
//   state      | meaning
//   ST_IDLE    | ready for an op; accepted fields latched on OpValid
//   ST_EXEC    | ALU/STORE/NOP completes: single write, Done
//   ST_LD_WAIT | RAM read of the latched address in flight
//   ST_LD_WB   | RAM data written back to RF, Done
module pdatapath_seq
    import pdatapath_pkg::*;
#(
    parameter int  DATA_W    = DATA_W_DEF,
    parameter int  RF_DEPTH  = RF_DEPTH_DEF,
    parameter int  RAM_DEPTH = RAM_DEPTH_DEF,
    localparam int RA_W      = $clog2(RF_DEPTH),
    localparam int MA_W      = $clog2(RAM_DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              OpValid,
    output logic              OpReady,
    input  logic [1:0]        OpCode,
    input  logic [2:0]        ALUSelect,
    input  logic [MA_W-1:0]   DAddr,
    input  logic [RA_W-1:0]   ReadAddrA,
    input  logic [RA_W-1:0]   ReadAddrB,
    input  logic [RA_W-1:0]   WriteAddr,
    output logic              Done,
    output logic [DATA_W-1:0] ALUOut,
    output logic [DATA_W-1:0] ALUAIn,
    output logic [DATA_W-1:0] ALUBIn
`ifdef PDATAPATH_FLAGS_EN
    ,
    output logic              FlagZ,
    output logic              FlagN,
    output logic              FlagC
`endif
);

    state_e            state, state_nxt;
    op_e               lat_op;
    alu_sel_e          lat_sel;
    logic [MA_W-1:0]   lat_daddr;
    logic [RA_W-1:0]   lat_a, lat_b, lat_w;

    logic [DATA_W-1:0] rf  [RF_DEPTH];
    logic [DATA_W-1:0] ram [RAM_DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic              rf_we, ram_we;
    logic [DATA_W-1:0] rf_wdata;
    logic              alu_carry;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            lat_op    <= OP_NOP;
            lat_sel   <= ALU_PASS;
            lat_daddr <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_w     <= '0;
        end else begin
            state <= state_nxt;
            if (OpValid && OpReady) begin
                lat_op    <= op_e'(OpCode);
                lat_sel   <= alu_sel_e'(ALUSelect);
                lat_daddr <= DAddr;
                lat_a     <= ReadAddrA;
                lat_b     <= ReadAddrB;
                lat_w     <= WriteAddr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        OpReady   = 1'b0;
        Done      = 1'b0;
        rf_we     = 1'b0;
        ram_we    = 1'b0;
        rf_wdata  = ALUOut;
        case (state)
            ST_IDLE: begin
                OpReady = 1'b1;
                if (OpValid)
                    state_nxt = (op_e'(OpCode) == OP_LOAD) ? ST_LD_WAIT : ST_EXEC;
            end
            ST_EXEC: begin
                Done      = 1'b1;
                rf_we     = (lat_op == OP_ALU);
                ram_we    = (lat_op == OP_STORE);
                state_nxt = ST_IDLE;
            end
            ST_LD_WAIT: state_nxt = ST_LD_WB;
            ST_LD_WB: begin
                Done      = 1'b1;
                rf_we     = 1'b1;
                rf_wdata  = ram_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // a reset cycle aborts the op outright: no completion, no writes
        if (Reset) begin
            Done   = 1'b0;
            rf_we  = 1'b0;
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (rf_we)
            rf[lat_w] <= rf_wdata;
    end

    always_ff @(posedge Clk) begin
        if (ram_we)
            ram[lat_daddr] <= rf[lat_a];
        ram_q <= ram[lat_daddr];
    end

    assign ALUAIn = rf[lat_a];
    assign ALUBIn = rf[lat_b];

    pdp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (ALUAIn),
        .b      (ALUBIn),
        .sel    (lat_sel),
        .result (ALUOut),
        .carry  (alu_carry)
    );

`ifdef PDATAPATH_FLAGS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FlagZ <= 1'b0;
            FlagN <= 1'b0;
            FlagC <= 1'b0;
        end else if (state == ST_EXEC && lat_op == OP_ALU) begin
            FlagZ <= (ALUOut == '0);
            FlagN <= ALUOut[DATA_W-1];
            FlagC <= alu_carry;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

endmodule

// File: tb/tb_pdatapath_seq.sv
// Self-checking bench for pdatapath_seq: cycle-level reference model, ALU vector table,
// directed handshake/reset sequences and randomized op streams.
module tb_pdatapath_seq;

    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] LD  = 2'd1;
    localparam logic [1:0] ST  = 2'd2;
    localparam logic [1:0] ALU = 2'd3;

    logic        clk = 1'b0;
    logic        reset, op_valid, op_ready, done;
    logic [1:0]  op_code;
    logic [2:0]  alu_select;
    logic [7:0]  d_addr;
    logic [3:0]  read_addr_a, read_addr_b, write_addr;
    logic [15:0] alu_out, alu_a_in, alu_b_in;
`ifdef PDATAPATH_FLAGS_EN
    logic        flag_z, flag_n, flag_c;
`endif

    always #5 clk = ~clk;

    pdatapath_seq dut (
        .Clk       (clk),
        .Reset     (reset),
        .OpValid   (op_valid),
        .OpReady   (op_ready),
        .OpCode    (op_code),
        .ALUSelect (alu_select),
        .DAddr     (d_addr),
        .ReadAddrA (read_addr_a),
        .ReadAddrB (read_addr_b),
        .WriteAddr (write_addr),
        .Done      (done),
        .ALUOut    (alu_out),
        .ALUAIn    (alu_a_in),
        .ALUBIn    (alu_b_in)
`ifdef PDATAPATH_FLAGS_EN
        ,
        .FlagZ     (flag_z),
        .FlagN     (flag_n),
        .FlagC     (flag_c)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [15:0] m_rf  [16];
    logic        m_rfk [16];
    logic [15:0] m_ram [256];
    int          m_rem;
    logic [1:0]  m_op;
    logic [2:0]  m_sel;
    logic [7:0]  m_da;
    logic [3:0]  m_a, m_b, m_w;
    logic        m_fz, m_fn, m_fc, m_fk;
    logic [15:0] last_alu;
    logic        done_seen;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic        c;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_alu(input logic [2:0] sel, input logic [15:0] a,
                                            input logic [15:0] b);
        int unsigned ia, ib, r;
        logic        c;
        ia = a;
        ib = b;
        c  = 1'b0;
        r  = 0;
        case (sel)
            3'd0: r = ia;
            3'd1: begin r = ia + ib; c = (r > 32'd65535); end
            3'd2: begin r = ia + 32'd65536 - ib; c = (ia < ib); end
            3'd3: r = ia & ib;
            3'd4: r = ia | ib;
            3'd5: r = ia ^ ib;
            3'd6: r = 32'd65535 - ia;
            default: r = ia * 2;
        endcase
        r = r % 32'd65536;
        return {c, r[15:0]};
    endfunction

    // One clock cycle: drive at the falling edge, check just after, advance the model on the rising edge.
    task automatic step(input logic rst, input logic v, input logic [1:0] op, input logic [2:0] sel,
                        input logic [7:0] da, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] w);
        logic [16:0] r;
        logic        rk;
        reset       = rst;
        op_valid    = v;
        op_code     = op;
        alu_select  = sel;
        d_addr      = da;
        read_addr_a = a;
        read_addr_b = b;
        write_addr  = w;
        #1;
        done_seen = done;
        chk("op_ready", op_ready, m_rem == 0);
        chk("done", done, (m_rem == 1) && !rst);
        if (m_rfk[m_a]) chk("alu_a_in", alu_a_in, m_rf[m_a]);
        if (m_rfk[m_b]) chk("alu_b_in", alu_b_in, m_rf[m_b]);
        r  = ref_alu(m_sel, m_rf[m_a], m_rf[m_b]);
        rk = m_rfk[m_a] && m_rfk[m_b];
        if (m_sel == 3'd5 && m_a == m_b) begin
            r  = 17'd0;
            rk = 1'b1;
        end
        if (m_rem == 1 && m_op == ALU && !rst) begin
            if (rk) chk("alu_out", alu_out, r[15:0]);
            last_alu = alu_out;
        end
`ifdef PDATAPATH_FLAGS_EN
        if (m_fk) begin
            chk("flag_z", flag_z, m_fz);
            chk("flag_n", flag_n, m_fn);
            chk("flag_c", flag_c, m_fc);
        end
`endif
        @(posedge clk);
        if (rst) begin
            m_rem = 0;
            m_op  = NOP;
            m_sel = 3'd0;
            m_da  = 8'd0;
            m_a   = 4'd0;
            m_b   = 4'd0;
            m_w   = 4'd0;
            m_fz  = 1'b0;
            m_fn  = 1'b0;
            m_fc  = 1'b0;
            m_fk  = 1'b1;
        end else if (m_rem == 0) begin
            if (v) begin
                m_op  = op;
                m_sel = sel;
                m_da  = da;
                m_a   = a;
                m_b   = b;
                m_w   = w;
                m_rem = (op == LD) ? 2 : 1;
            end
        end else begin
            if (m_rem == 1) begin
                case (m_op)
                    ALU: begin
                        m_rf[m_w]  = r[15:0];
                        m_rfk[m_w] = rk;
                        m_fz = (r[15:0] == 16'd0);
                        m_fn = r[15];
                        m_fc = r[16];
                        m_fk = rk;
                    end
                    ST: m_ram[m_da] = m_rf[m_a];
                    LD: begin
                        m_rf[m_w]  = m_ram[m_da];
                        m_rfk[m_w] = 1'b1;
                    end
                    default: ;
                endcase
            end
            m_rem--;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [7:0] da,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] w,
                         output int lat);
        lat = 0;
        step(1'b0, 1'b1, op, sel, da, a, b, w);
        for (int k = 1; k <= 4 && m_rem != 0; k++) begin
            step(1'b0, 1'b0, op, sel, da, a, b, w);
            if (done_seen) lat = k;
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [2:0] sel, input logic [7:0] da,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] w);
        int l;
        issue(op, sel, da, a, b, w, l);
    endtask

    task automatic read_reg(input string name, input logic [3:0] r, input logic [15:0] exp);
        run(NOP, 3'd0, 8'd0, r, 4'd0, 4'd0);
        chk(name, alu_a_in, exp);
    endtask

    // Builds a constant with ALU ops only: R14=~0, R13=0-R14=1, then shift-and-add into dst.
    task automatic set_reg(input logic [3:0] dst, input logic [15:0] val);
        run(ALU, 3'd5, 8'd0, dst, dst, dst);
        run(ALU, 3'd5, 8'd0, 4'd14, 4'd14, 4'd14);
        run(ALU, 3'd6, 8'd0, 4'd14, 4'd0, 4'd14);
        run(ALU, 3'd5, 8'd0, 4'd13, 4'd13, 4'd13);
        run(ALU, 3'd2, 8'd0, 4'd13, 4'd14, 4'd13);
        for (int i = 15; i >= 0; i--) begin
            run(ALU, 3'd7, 8'd0, dst, 4'd0, dst);
            if (val[i]) run(ALU, 3'd1, 8'd0, dst, 4'd13, dst);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nd;
        logic [1:0] hold_op [9];
        logic [2:0] hold_sel [9];
        logic [7:0] hold_da [9];
        logic [3:0] hold_a [9];
        logic [3:0] hold_w [9];
        logic rr;

        vt[0]  = '{"add_wrap",  3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vt[1]  = '{"sub_borrow",3'd2, 16'h0003, 16'h0005, 16'hFFFE, 1'b1};
        vt[2]  = '{"pass",      3'd0, 16'h1234, 16'h5678, 16'h1234, 1'b0};
        vt[3]  = '{"and",       3'd3, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
        vt[4]  = '{"or",        3'd4, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0};
        vt[5]  = '{"xor",       3'd5, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0};
        vt[6]  = '{"not",       3'd6, 16'h1234, 16'h0000, 16'hEDCB, 1'b0};
        vt[7]  = '{"shl",       3'd7, 16'h8001, 16'h0000, 16'h0002, 1'b0};
        vt[8]  = '{"add_ovf",   3'd1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
        vt[9]  = '{"sub_nb",    3'd2, 16'h8000, 16'h0001, 16'h7FFF, 1'b0};
        vt[10] = '{"sub_zero",  3'd2, 16'h0005, 16'h0005, 16'h0000, 1'b0};

        reset = 1'b1; op_valid = 1'b0; op_code = 2'd0; alu_select = 3'd0;
        d_addr = 8'd0; read_addr_a = 4'd0; read_addr_b = 4'd0; write_addr = 4'd0;
        m_rem = 0; m_op = NOP; m_sel = 3'd0; m_da = 8'd0; m_a = 4'd0; m_b = 4'd0; m_w = 4'd0;
        m_fz = 1'b0; m_fn = 1'b0; m_fc = 1'b0; m_fk = 1'b1;
        for (int i = 0; i < 16; i++) begin m_rf[i] = 16'd0; m_rfk[i] = 1'b0; end
        for (int i = 0; i < 256; i++) m_ram[i] = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset holds the block idle even with a request pending
        step(1'b1, 1'b1, LD, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b1, ALU, 3'd1, 8'd0, 4'd0, 4'd0, 4'd0);

        for (int r = 0; r < 16; r++) run(ALU, 3'd5, 8'd0, 4'(r), 4'(r), 4'(r));
        for (int d = 0; d < 256; d++) run(ST, 3'd0, 8'(d), 4'd0, 4'd0, 4'd0);

        // LOAD latency and basic ALU/STORE flow
        set_reg(4'd10, 16'd5);
        run(ST, 3'd0, 8'h1A, 4'd10, 4'd0, 4'd0);
        issue(LD, 3'd0, 8'h1A, 4'd0, 4'd0, 4'd0, lat);
        chk("load_latency", lat, 2);
        read_reg("load_r0", 4'd0, 16'd5);
        set_reg(4'd10, 16'd3);
        run(ST, 3'd0, 8'h2B, 4'd10, 4'd0, 4'd0);
        run(LD, 3'd0, 8'h2B, 4'd0, 4'd0, 4'd1);
        issue(ALU, 3'd1, 8'd0, 4'd0, 4'd1, 4'd2, lat);
        chk("alu_latency", lat, 1);
        chk("add_result", last_alu, 16'd8);
        read_reg("rf2", 4'd2, 16'd8);
        run(ALU, 3'd2, 8'd0, 4'd1, 4'd0, 4'd3);
        read_reg("rf3_wrap", 4'd3, 16'hFFFE);
        issue(ST, 3'd0, 8'd1, 4'd3, 4'd0, 4'd0, lat);
        chk("store_latency", lat, 1);
        run(LD, 3'd0, 8'd1, 4'd0, 4'd0, 4'd4);
        read_reg("rf4_roundtrip", 4'd4, 16'hFFFE);

`ifdef PDATAPATH_FLAGS_EN
        set_reg(4'd5, 16'hFFFF);
        set_reg(4'd6, 16'h0001);
        run(ALU, 3'd1, 8'd0, 4'd5, 4'd6, 4'd7);
        chk("fz_add", flag_z, 1'b1);
        chk("fc_add", flag_c, 1'b1);
        chk("fn_add", flag_n, 1'b0);
        run(LD, 3'd0, 8'd1, 4'd0, 4'd0, 4'd4);
        chk("fz_after_load", flag_z, 1'b1);
        chk("fc_after_load", flag_c, 1'b1);
        chk("fn_after_load", flag_n, 1'b0);
`endif

        // OpValid held high across busy windows: only ops offered while idle take effect
        set_reg(4'd9, 16'h00F0);
        hold_op  = '{LD,    ALU,   ST,    NOP,   ALU,   LD,    ALU,   ST,    ALU};
        hold_sel = '{3'd0,  3'd6,  3'd0,  3'd0,  3'd6,  3'd0,  3'd6,  3'd0,  3'd5};
        hold_da  = '{8'h1A, 8'h00, 8'h33, 8'h00, 8'h00, 8'h1A, 8'h00, 8'h33, 8'h00};
        hold_a   = '{4'd0,  4'd9,  4'd9,  4'd0,  4'd9,  4'd0,  4'd9,  4'd9,  4'd11};
        hold_w   = '{4'd8,  4'd9,  4'd9,  4'd0,  4'd9,  4'd8,  4'd9,  4'd9,  4'd11};
        nd = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, hold_op[i], hold_sel[i], hold_da[i], hold_a[i], hold_a[i], hold_w[i]);
            if (done_seen) nd++;
        end
        for (int k = 0; k < 4 && m_rem != 0; k++) begin
            step(1'b0, 1'b0, NOP, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0);
            if (done_seen) nd++;
        end
        chk("hold_done_count", nd, 4);
        read_reg("hold_r9", 4'd9, 16'h00F0);
        read_reg("hold_r8", 4'd8, 16'd5);
        run(LD, 3'd0, 8'h33, 4'd0, 4'd0, 4'd10);
        read_reg("hold_ram33", 4'd10, 16'd0);

        // reset in LD_WAIT, LD_WB and EXEC
        set_reg(4'd12, 16'h0ABC);
        step(1'b0, 1'b1, LD, 3'd0, 8'h1A, 4'd2, 4'd2, 4'd12);
        step(1'b1, 1'b0, NOP, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0);
        chk("rst_wait_done", done_seen, 1'b0);
        chk("rst_wait_ready", op_ready, 1'b1);
        chk("rst_ain_rf0", alu_a_in, 16'd5);
        read_reg("rst_wait_r12", 4'd12, 16'h0ABC);
        step(1'b0, 1'b1, LD, 3'd0, 8'h1A, 4'd0, 4'd0, 4'd12);
        step(1'b0, 1'b0, NOP, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b0, NOP, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0);
        chk("rst_wb_done", done_seen, 1'b0);
        read_reg("rst_wb_r12", 4'd12, 16'h0ABC);
        step(1'b0, 1'b1, ALU, 3'd6, 8'd0, 4'd12, 4'd0, 4'd12);
        step(1'b1, 1'b0, NOP, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0);
        chk("rst_exec_done", done_seen, 1'b0);
        read_reg("rst_exec_r12", 4'd12, 16'h0ABC);

        // ALU function table
        for (int i = 0; i < 11; i++) begin
            set_reg(4'd1, vt[i].a);
            set_reg(4'd2, vt[i].b);
            run(ALU, vt[i].sel, 8'd0, 4'd1, 4'd2, 4'd3);
            chk(vt[i].name, last_alu, vt[i].y);
`ifdef PDATAPATH_FLAGS_EN
            chk({vt[i].name, "_c"}, flag_c, vt[i].c);
            chk({vt[i].name, "_z"}, flag_z, vt[i].y == 16'd0);
`endif
            read_reg({vt[i].name, "_rf"}, 4'd3, vt[i].y);
        end

        // random op streams with random valid gaps and occasional resets
        for (int i = 0; i < 900; i++) begin
            rr = ($urandom_range(0, 59) == 0);
            step(rr, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 4 && m_rem != 0; k++)
            step(1'b0, 1'b0, NOP, 3'd0, 8'd0, 4'd0, 4'd0, 4'd0);
        for (int r = 0; r < 16; r++)
            read_reg("final_rf", 4'(r), m_rf[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
